// File: rtl/usb_acq_sched.sv
// Acquisition scheduler and single-writer USB uplink arbiter: decodes host commands, fires
// triggers, frames ADC samples into packets and interleaves status replies at packet boundaries.
module usb_acq_sched #(
  parameter int unsigned LEN_W     = 14,
  parameter logic [15:0] HDR_WORD  = 16'hA55A,
  parameter logic [15:0] STAT_WORD = 16'h5AA5
) (
  input  logic        i_clk_sys,
  input  logic        i_rst,
  input  logic        i_cmd_come,
  input  logic [7:0]  i_cmd,
  input  logic [31:0] i_cmd_param,
  output logic        o_trig,
  input  logic        i_smp_valid,
  input  logic [15:0] i_smp_data,
  output logic        o_smp_ready,
  output logic        o_wr,
  output logic [15:0] o_wr_data,
  input  logic        i_full,
  output logic        o_busy,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [3:0] {
    StIdle, StTrig, StHdr0, StHdr1, StHdr2, StData, StCsum, StStat0, StStat1, StStat2
  } state_e;

  state_e             state_q, state_d;
  logic               stat_pend_q, stat_pend_d;
  logic               stop_q, stop_d;
  logic               run_q, run_d;
  logic [15:0]        tgt_q, tgt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [15:0]        csum_q, csum_d;
  logic [15:0]        idx_q, idx_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic        cmd_start, cmd_stop, cmd_status;
  logic        stat_now, stop_now;
  logic        word_pend, wr;
  logic [15:0] wr_data;
  logic [15:0] cnt_inc;
  logic        tgt_hit, tgt_hit_inc;
  logic        unused_param;

  assign unused_param = ^i_cmd_param[15:LEN_W];

  assign cmd_start  = i_cmd_come && (i_cmd == 8'h01);
  assign cmd_stop   = i_cmd_come && (i_cmd == 8'h02);
  assign cmd_status = i_cmd_come && (i_cmd == 8'h03);

  // Same-cycle commands count as already registered so STATUS+STOP are both honoured.
  assign stat_now = stat_pend_q | cmd_status;
  assign stop_now = stop_q | (cmd_stop & run_q);

  assign cnt_inc     = frame_cnt_q + 16'd1;
  assign tgt_hit     = (tgt_q != 16'd0) && (frame_cnt_q == tgt_q);
  assign tgt_hit_inc = (tgt_q != 16'd0) && (cnt_inc == tgt_q);

  always_comb begin
    word_pend = 1'b0;
    wr_data   = 16'h0000;
    unique case (state_q)
      StHdr0:  begin word_pend = 1'b1; wr_data = HDR_WORD; end
      StHdr1:  begin word_pend = 1'b1; wr_data = idx_q; end
      StHdr2:  begin word_pend = 1'b1; wr_data = {{(16-LEN_W){1'b0}}, len_q}; end
      StData:  begin word_pend = i_smp_valid; wr_data = i_smp_data; end
      StCsum:  begin word_pend = 1'b1; wr_data = csum_q; end
      StStat0: begin word_pend = 1'b1; wr_data = STAT_WORD; end
      StStat1: begin word_pend = 1'b1; wr_data = {14'b0, run_q, stop_q}; end
      StStat2: begin word_pend = 1'b1; wr_data = frame_cnt_q; end
      default: ;
    endcase
  end

  // Reset gates the combinational outputs so they drop in the reset cycle itself.
  assign wr          = word_pend && !i_full && !i_rst;
  assign o_wr        = wr;
  assign o_wr_data   = i_rst ? 16'h0000 : wr_data;
  assign o_smp_ready = (state_q == StData) && !i_full && !i_rst;
  assign o_trig      = (state_q == StTrig) && !i_rst;
  assign o_busy      = (state_q != StIdle) && !i_rst;
  assign o_frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    stat_pend_d = stat_pend_q | cmd_status;
    stop_d      = stop_now;
    run_d       = run_q;
    tgt_d       = tgt_q;
    len_d       = len_q;
    smp_cnt_d   = smp_cnt_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (stat_now) begin
          state_d     = StStat0;
          stat_pend_d = 1'b0;
        end else if (cmd_start) begin
          state_d     = StTrig;
          tgt_d       = i_cmd_param[31:16];
          len_d       = (i_cmd_param[LEN_W-1:0] == '0) ? LEN_W'(1) : i_cmd_param[LEN_W-1:0];
          frame_cnt_d = 16'd0;
          stop_d      = 1'b0;
          run_d       = 1'b1;
        end
      end
      StTrig: begin
        smp_cnt_d = '0;
        csum_d    = 16'd0;
        state_d   = StHdr0;
      end
      StHdr0:  if (wr) state_d = StHdr1;
      StHdr1:  if (wr) state_d = StHdr2;
      StHdr2:  if (wr) state_d = StData;
      StData: begin
        if (wr) begin
          csum_d    = csum_q + i_smp_data;
          smp_cnt_d = smp_cnt_q + LEN_W'(1);
          if (smp_cnt_q == len_q - LEN_W'(1)) state_d = StCsum;
        end
      end
      StCsum: begin
        if (wr) begin
          frame_cnt_d = cnt_inc;
          idx_d       = idx_q + 16'd1;
          if (stat_now) begin
            state_d     = StStat0;
            stat_pend_d = 1'b0;
          end else if (stop_now || tgt_hit_inc) begin
            state_d = StIdle;
            run_d   = 1'b0;
            stop_d  = 1'b0;
          end else begin
            state_d = StTrig;
          end
        end
      end
      StStat0: if (wr) state_d = StStat1;
      StStat1: if (wr) state_d = StStat2;
      StStat2: begin
        if (wr) begin
          if (run_q && !stop_now && !tgt_hit) begin
            state_d = StTrig;
          end else begin
            state_d = StIdle;
            run_d   = 1'b0;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      state_q     <= StIdle;
      stat_pend_q <= 1'b0;
      stop_q      <= 1'b0;
      run_q       <= 1'b0;
      tgt_q       <= 16'd0;
      len_q       <= '0;
      smp_cnt_q   <= '0;
      csum_q      <= 16'd0;
      idx_q       <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stat_pend_q <= stat_pend_d;
      stop_q      <= stop_d;
      run_q       <= run_d;
      tgt_q       <= tgt_d;
      len_q       <= len_d;
      smp_cnt_q   <= smp_cnt_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule
